banco_registradores_param: RTL and testbench

Parametrised multi-port register bank: the next generation of the 8-bit, 16-entry, two-read-port register bank used by the datapath. It adds configurable width, depth and read-port count, registered reads with fixed one-cycle latency, optional write-to-read forwarding, and a cycle-by-cycle clear sweep, so the array never needs a combinational multi-entry reset. It sits between instruction decode (read/write addresses) and the ALU/write-back stage.

---
 rtl/banco_pkg.sv | 8 +
 rtl/banco_registradores_param_if.sv | 17 +
 rtl/banco_porta_leitura.sv | 32 +++
 rtl/banco_registradores_param.sv | 53 +++++
 tb/tb_banco_registradores_param.sv | 113 +++++++++++
 5 files changed

// File: rtl/banco_pkg.sv
// banco_pkg: shared sweep FSM state type and default sizes for the register bank.
package banco_pkg;
  typedef logic [0:0] estado_t;
  localparam estado_t OCIOSO = 1'b0;
  localparam estado_t LIMPANDO = 1'b1;
  localparam int LARGURA_PADRAO = 8;
  localparam int PROFUNDIDADE_PADRAO = 16;
endpackage

// File: rtl/banco_registradores_param_if.sv
// banco_registradores_param_if: decode/write-back bus of the register bank.
interface banco_registradores_param_if #(
  parameter int LARGURA = 8,
  parameter int PROFUNDIDADE = 16,
  parameter int NUM_LEITURA = 2
);
  localparam int AW = $clog2(PROFUNDIDADE);
  logic                           write;
  logic [AW-1:0]                  registradorEscrita;
  logic [LARGURA-1:0]             dado;
  logic [NUM_LEITURA*AW-1:0]      entrada;
  logic                           limpa;
  logic [NUM_LEITURA*LARGURA-1:0] saida;
  logic                           ocupado;
  modport master (output write, registradorEscrita, dado, entrada, limpa, input saida, ocupado);
  modport slave (input write, registradorEscrita, dado, entrada, limpa, output saida, ocupado);
endinterface

// File: rtl/banco_porta_leitura.sv
// banco_porta_leitura: one registered read port with optional write forwarding.
// Forwarding is compiled in when BANCO_BYPASS_EN is defined.
module banco_porta_leitura #(
  parameter int LARGURA = 8,
  parameter int AW = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               i_limpando,
  input  logic [AW-1:0]      i_end_leitura,
  input  logic [LARGURA-1:0] i_dado_mem,
  input  logic               i_escreve,
  input  logic [AW-1:0]      i_end_escrita,
  input  logic [LARGURA-1:0] i_dado_escrita,
  output logic [LARGURA-1:0] o_saida
);
`ifdef BANCO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic               w_colisao;
  logic [LARGURA-1:0] w_valor;
  logic [LARGURA-1:0] r_saida;
  assign w_colisao = i_escreve && (i_end_escrita == i_end_leitura);
  assign w_valor   = (BYPASS && w_colisao) ? i_dado_escrita : i_dado_mem;
  // stale array contents must not leak out while the sweep is running
  always_ff @(posedge clk or posedge clr)
    if (clr) r_saida <= '0;
    else r_saida <= i_limpando ? '0 : w_valor;
  assign o_saida = r_saida;
endmodule

// File: rtl/banco_registradores_param.sv
// banco_registradores_param: multi-port register bank with a one-entry-per-cycle clear sweep.
// Optional same-cycle write forwarding: BANCO_BYPASS_EN.
module banco_registradores_param
  import banco_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO,
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter int NUM_LEITURA = 2
) (
  input logic clk,
  input logic clr,
  banco_registradores_param_if.slave bus
);
  localparam int AW = $clog2(PROFUNDIDADE);
  logic [LARGURA-1:0]             r_mem [PROFUNDIDADE];
  estado_t                        r_estado;
  logic [AW-1:0]                  r_ptr;
  logic                           w_limpando;
  logic                           w_escreve;
  logic [NUM_LEITURA*LARGURA-1:0] w_saida;
  assign w_limpando = (r_estado == LIMPANDO);
  assign w_escreve  = !w_limpando && !bus.limpa && bus.write;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      r_estado <= LIMPANDO;
      r_ptr    <= '0;
    end else if (w_limpando) begin
      r_ptr <= r_ptr + 1'b1;
      if (&r_ptr) r_estado <= OCIOSO;
    end else if (bus.limpa) begin
      r_estado <= LIMPANDO;
      r_ptr    <= '0;
    end
  // array has no reset; the sweep zeroes it one entry per edge
  always_ff @(posedge clk)
    if (w_limpando) r_mem[r_ptr] <= '0;
    else if (w_escreve) r_mem[bus.registradorEscrita] <= bus.dado;
  for (genvar g = 0; g < NUM_LEITURA; g++) begin : g_porta
    banco_porta_leitura #(.LARGURA(LARGURA), .AW(AW)) u_porta (
      .clk           (clk),
      .clr           (clr),
      .i_limpando    (w_limpando),
      .i_end_leitura (bus.entrada[g*AW +: AW]),
      .i_dado_mem    (r_mem[bus.entrada[g*AW +: AW]]),
      .i_escreve     (w_escreve),
      .i_end_escrita (bus.registradorEscrita),
      .i_dado_escrita(bus.dado),
      .o_saida       (w_saida[g*LARGURA +: LARGURA])
    );
  end
  assign bus.saida   = w_saida;
  assign bus.ocupado = w_limpando;
endmodule

// File: tb/tb_banco_registradores_param.sv
// tb_banco_registradores_param: directed and random checks of the bank against an array model.
module tb_banco_registradores_param;
`ifdef BANCO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  banco_registradores_param_if #(.LARGURA(8), .PROFUNDIDADE(16), .NUM_LEITURA(2)) b1 ();
  banco_registradores_param_if #(.LARGURA(16), .PROFUNDIDADE(64), .NUM_LEITURA(3)) b2 ();
  banco_registradores_param #(.LARGURA(8), .PROFUNDIDADE(16), .NUM_LEITURA(2)) dut1 (.clk(clk), .clr(clr), .bus(b1));
  banco_registradores_param #(.LARGURA(16), .PROFUNDIDADE(64), .NUM_LEITURA(3)) dut2 (.clk(clk), .clr(clr), .bus(b2));

  int checks = 0;
  int failures = 0;
  logic [7:0] mdl [16];
  int restante = 16;
  int ciclos = 0;
  int queda2 = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] esperado(input logic [3:0] a, input logic w, input logic [3:0] wa,
                                          input logic [7:0] d, input logic lp);
    if (restante > 0) return 8'h00;
    if (BYP && w && !lp && wa == a) return d;
    return mdl[a];
  endfunction

  task automatic passo(input logic w, input logic [3:0] wa, input logic [7:0] d,
                       input logic [3:0] a0, input logic [3:0] a1, input logic lp, input string tag);
    logic [7:0] e0, e1;
    b1.write = w; b1.registradorEscrita = wa; b1.dado = d; b1.entrada = {a1, a0}; b1.limpa = lp;
    e0 = esperado(a0, w, wa, d, lp);
    e1 = esperado(a1, w, wa, d, lp);
    @(posedge clk); #1;
    if (restante > 0) begin
      mdl[16-restante] = 8'h00;
      restante--;
    end else if (lp) restante = 16;
    else if (w) mdl[wa] = d;
    ciclos++;
    if (!b2.ocupado && queda2 < 0) queda2 = ciclos;
    chk({tag, "_s0"}, 32'(b1.saida[7:0]), 32'(e0));
    chk({tag, "_s1"}, 32'(b1.saida[15:8]), 32'(e1));
    chk({tag, "_ocupado"}, 32'(b1.ocupado), 32'(restante > 0));
  endtask

  task automatic pulso_clr(input string tag);
    #2 clr = 1'b1;
    #1;
    chk({tag, "_saida"}, 32'(b1.saida), 32'h0);
    chk({tag, "_ocupado"}, 32'(b1.ocupado), 32'h1);
    chk({tag, "_saida2"}, 32'(b2.saida[31:0]), 32'h0);
    clr = 1'b0;
    restante = 16;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    b1.write = 0; b1.registradorEscrita = '0; b1.dado = '0; b1.entrada = '0; b1.limpa = 0;
    b2.write = 0; b2.registradorEscrita = '0; b2.dado = '0; b2.entrada = '0; b2.limpa = 0;
    #8;
    chk("reset_saida", 32'(b1.saida), 32'h0);
    chk("reset_ocupado", 32'(b1.ocupado), 32'h1);
    clr = 1'b0;
    for (int i = 0; i < 16; i++) passo(0, 0, 0, 4'(i), 4'(15 - i), 0, "sweep");
    for (int i = 0; i < 8; i++) passo(0, 0, 0, 4'(2*i), 4'(2*i + 1), 0, "zero_read");
    for (int i = 0; i < 16; i++) passo(1, 4'(i), 8'(i + 1), 0, 1, 0, "wr");
    passo(0, 0, 0, 15, 3, 0, "rd_15_3");
    chk("rd15_direct", 32'(b1.saida[7:0]), 32'h10);
    chk("rd3_direct", 32'(b1.saida[15:8]), 32'h04);
    passo(1, 5, 8'hAA, 0, 0, 0, "col_setup");
    passo(1, 5, 8'h55, 5, 5, 0, "col_same");
    chk("col_direct", 32'(b1.saida[7:0]), BYP ? 32'h55 : 32'hAA);
    passo(0, 0, 0, 5, 4, 0, "col_after");
    chk("col_after_direct", 32'(b1.saida[7:0]), 32'h55);
    passo(1, 2, 8'h77, 2, 2, 1, "limpa_wr");
    for (int i = 0; i < 16; i++) passo(0, 0, 0, 2, 5, 0, "limpa_sweep");
    passo(0, 0, 0, 2, 5, 0, "limpa_rd2");
    chk("limpa_rd2_direct", 32'(b1.saida[7:0]), 32'h00);
    while (queda2 < 0 && ciclos < 120) passo(0, 0, 0, 0, 0, 0, "idle2");
    chk("p2_ocupado_edges", 32'(queda2), 32'd64);
    b2.write = 1; b2.registradorEscrita = 6'd63; b2.dado = 16'hBEEF;
    passo(0, 0, 0, 0, 0, 0, "p2_wr");
    b2.write = 0; b2.entrada = {6'd63, 6'd63, 6'd63};
    passo(0, 0, 0, 0, 0, 0, "p2_rd");
    for (int k = 0; k < 3; k++) chk($sformatf("p2_porta%0d", k), 32'(b2.saida[k*16 +: 16]), 32'hBEEF);
    for (int i = 0; i < 8; i++) passo(1, 4'(i), 8'(8'hC0 + i), 0, 0, 0, "pre_mid");
    passo(0, 0, 0, 0, 0, 1, "mid_limpa");
    for (int i = 0; i < 7; i++) passo(0, 0, 0, 1, 2, 0, "mid_sweep");
    pulso_clr("mid_clr");
    for (int i = 0; i < 17; i++) passo(0, 0, 0, 4'(i), 3, 0, "mid_resweep");
    for (int i = 0; i < 300; i++)
      passo(1'($urandom), 4'($urandom), 8'($urandom), 4'($urandom), 4'($urandom),
            ($urandom_range(0, 39) == 0), "rnd");
    passo(1, 9, 8'h3C, 9, 9, 0, "fim_wr");
    passo(0, 0, 0, 9, 9, 0, "fim_rd");
    pulso_clr("fim_clr");
    for (int i = 0; i < 18; i++) passo(0, 0, 0, 9, 4'(i), 0, "fim_sweep");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
